// File: rtl/switch_port.sv
// Debounced switch inputs with per-channel edge capture,
// a wrapping event counter and a registered interrupt line.
module switch_port #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = 2
) (
    input  logic                clock,
    input  logic                isReset,
    input  logic [CHANNELS-1:0] switch,
    input  logic [CHANNELS-1:0] clearPending,
    output logic [CHANNELS-1:0] switchState,
    output logic [CHANNELS-1:0] pending,
    output logic [7:0]          eventCount,
    output logic                interrupt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [CHANNELS-1:0] accept;
    logic [CHANNELS-1:0] qualify;
    logic [CW-1:0]       cnt [CHANNELS];
    logic [7:0]          hits;

    always_ff @(posedge clock or posedge isReset) begin
        if (isReset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= switch;
            sync2 <= sync1;
        end
    end

    // A change is accepted on the sample that completes the stable run
    always_comb begin
        accept = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            accept[i] = (sync2[i] != switchState[i]) && (cnt[i] == LAST);
        end
    end

    always_ff @(posedge clock or posedge isReset) begin
        if (isReset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (sync2[i] == switchState[i] || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        qualify = '0;
        unique case (EDGE_MODE)
            0:       qualify = accept & sync2;
            1:       qualify = accept & ~sync2;
            default: qualify = accept;
        endcase
    end

    always_comb begin
        hits = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            hits = hits + 8'(qualify[i]);
        end
    end

    // New edges win over a same-cycle clear request
    always_ff @(posedge clock or posedge isReset) begin
        if (isReset) begin
            switchState <= '0;
            pending     <= '0;
            eventCount  <= '0;
            interrupt   <= 1'b0;
        end else begin
            switchState <= switchState ^ accept;
            pending     <= qualify | (pending & ~clearPending);
            eventCount  <= eventCount + hits;
            interrupt   <= |pending;
        end
    end

endmodule

// File: tb/tb_switch_port.sv
// Scoreboard bench for switch_port: a run-length reference model
// predicts accepted level changes, a monitor checks the DUTs.
module tb_switch_port;

    localparam int D = 16;

    logic clock;
    logic isReset;
    logic [3:0] switch;
    logic [3:0] clearPending;
    logic [1:0][3:0] ss;
    logic [1:0][3:0] pd;
    logic [1:0][7:0] ec;
    logic [1:0] ir;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        int cyc;
        logic [3:0] st;
        logic [3:0] pd;
        logic [7:0] cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    switch_port #(.CHANNELS(4), .DEBOUNCE_CYCLES(D), .EDGE_MODE(2)) dut (
        .clock(clock),
        .isReset(isReset),
        .switch(switch),
        .clearPending(clearPending),
        .switchState(ss[0]),
        .pending(pd[0]),
        .eventCount(ec[0]),
        .interrupt(ir[0])
    );

    switch_port #(.CHANNELS(4), .DEBOUNCE_CYCLES(D), .EDGE_MODE(0)) dut0 (
        .clock(clock),
        .isReset(isReset),
        .switch(switch),
        .clearPending(clearPending),
        .switchState(ss[1]),
        .pending(pd[1]),
        .eventCount(ec[1]),
        .interrupt(ir[1])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a level is accepted once D consecutive
    // synchronised samples (raw input two clocks old) differ from it.
    logic [3:0] h_old, h_prev, mst;
    logic [1:0][3:0] mpd;
    logic [1:0][7:0] mcnt;
    int run [4];

    initial begin
        logic [3:0] lvl, acc, qual;
        int mode;
        forever begin
            @(posedge clock);
            cyc++;
            if (isReset) begin
                h_old = '0; h_prev = '0; mst = '0;
                mpd = '0; mcnt = '0;
                for (int i = 0; i < 4; i++) run[i] = 0;
            end else begin
                lvl = h_old;
                h_old = h_prev;
                h_prev = switch;
                acc = '0;
                for (int i = 0; i < 4; i++) begin
                    if (lvl[i] != mst[i]) begin
                        run[i]++;
                        if (run[i] == D) begin
                            mst[i] = lvl[i];
                            run[i] = 0;
                            acc[i] = 1'b1;
                        end
                    end else begin
                        run[i] = 0;
                    end
                end
                for (int n = 0; n < 2; n++) begin
                    mode = (n == 0) ? 2 : 0;
                    if (mode == 0) qual = acc & mst;
                    else if (mode == 1) qual = acc & ~mst;
                    else qual = acc;
                    mpd[n] = qual | (mpd[n] & ~clearPending);
                    mcnt[n] = mcnt[n] + 8'($countones(qual));
                    if (acc != 0) begin
                        if (n == 0) q0.push_back('{cyc, mst, mpd[n], mcnt[n]});
                        else q1.push_back('{cyc, mst, mpd[n], mcnt[n]});
                    end
                end
            end
        end
    end

    // Monitor: every observed switchState change must match the queue head
    initial begin
        logic [1:0][3:0] prev;
        exp_t e;
        int sz;
        prev = '0;
        forever begin
            @(negedge clock);
            for (int n = 0; n < 2; n++) begin
                sz = (n == 0) ? q0.size() : q1.size();
                if (isReset) begin
                    prev[n] = ss[n];
                end else if (ss[n] !== prev[n]) begin
                    if (sz == 0) begin
                        tests++; fails++;
                        $display("FAIL sb_unexpected[%0d]: got %0h expected %0h", n, ss[n], prev[n]);
                    end else begin
                        e = (n == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("sb_cycle[%0d]", n), cyc, e.cyc);
                        chk($sformatf("sb_state[%0d]", n), ss[n], e.st);
                        chk($sformatf("sb_pending[%0d]", n), pd[n], e.pd);
                        chk($sformatf("sb_count[%0d]", n), ec[n], e.cnt);
                    end
                    prev[n] = ss[n];
                end else if (sz != 0) begin
                    e = (n == 0) ? q0[0] : q1[0];
                    if (e.cyc < cyc) begin
                        tests++; fails++;
                        $display("FAIL sb_missed[%0d]: got %0h expected %0h", n, ss[n], e.st);
                        if (n == 0) void'(q0.pop_front());
                        else void'(q1.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    initial begin
        int need;
        isReset = 1'b1;
        switch = '0;
        clearPending = '0;
        tick(3);
        chk("rst_state", ss[0], 0);
        chk("rst_pending", pd[0], 0);
        chk("rst_count", ec[0], 0);
        chk("rst_irq", ir[0], 0);
        isReset = 1'b0;
        tick(2);

        // clean press
        switch = 4'b0001;
        tick(17);
        chk("press_early", ss[0][0], 0);
        tick(1);
        chk("press_state", ss[0][0], 1);
        chk("press_pending", pd[0][0], 1);
        chk("press_count", ec[0], 1);
        chk("press_irq_lag", ir[0], 0);
        tick(1);
        chk("press_irq", ir[0], 1);
        tick(21);
        clearPending = 4'hF;
        tick(1);
        clearPending = '0;
        chk("clear_pending", pd[0], 0);
        tick(1);
        chk("clear_irq", ir[0], 0);

        // glitch rejection
        switch = 4'b0011;
        tick(10);
        switch = 4'b0001;
        tick(30);
        chk("glitch_state", ss[0], 4'b0001);
        chk("glitch_pending", pd[0], 0);
        chk("glitch_count", ec[0], 1);

        // set wins over same-cycle clear
        switch = 4'b0101;
        tick(17);
        clearPending = 4'b0100;
        tick(1);
        chk("setclr_state", ss[0][2], 1);
        chk("setclr_pending", pd[0][2], 1);
        tick(1);
        clearPending = '0;
        chk("clr_next_pending", pd[0][2], 0);
        chk("clr_next_irq", ir[0], 1);
        tick(1);
        chk("clr_irq_drop", ir[0], 0);
        chk("setclr_count", ec[0], 2);

        // randomized phase
        repeat (150) begin
            switch = 4'($urandom);
            if ($urandom_range(0, 3) == 0) clearPending = 4'($urandom);
            else clearPending = '0;
            tick($urandom_range(1, 30));
        end
        clearPending = '0;
        tick(25);
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("rand_pending[%0d]", n), pd[n], mpd[n]);
            chk($sformatf("rand_count[%0d]", n), ec[n], mcnt[n]);
        end

        // drive the counter to 254, then four events wrap it to 2
        need = (254 - int'(mcnt[0]) + 256) % 256;
        for (int k = 0; k < need / 4; k++) begin
            switch = ~switch;
            tick(20);
        end
        for (int k = 0; k < need % 4; k++) begin
            switch[0] = ~switch[0];
            tick(20);
        end
        chk("wrap_pre", ec[0], 254);
        switch = ~switch;
        tick(20);
        chk("wrap_post", ec[0], 2);

        // rising-only mode on the second instance
        switch = '0;
        tick(20);
        isReset = 1'b1;
        tick(1);
        isReset = 1'b0;
        tick(2);
        switch = 4'b1000;
        tick(20);
        chk("rise_state", ss[1][3], 1);
        chk("rise_pending", pd[1][3], 1);
        chk("rise_count", ec[1], 1);
        clearPending = 4'hF;
        tick(1);
        clearPending = '0;
        switch = '0;
        tick(20);
        chk("fall_state", ss[1][3], 0);
        chk("fall_pending", pd[1][3], 0);
        chk("fall_count", ec[1], 1);
        chk("both_count", ec[0], 2);

        // reset in the middle of a debounce
        switch = 4'b0001;
        tick(12);
        isReset = 1'b1;
        #1;
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("mid_rst_state[%0d]", n), ss[n], 0);
            chk($sformatf("mid_rst_pending[%0d]", n), pd[n], 0);
            chk($sformatf("mid_rst_count[%0d]", n), ec[n], 0);
            chk($sformatf("mid_rst_irq[%0d]", n), ir[n], 0);
        end
        tick(1);
        isReset = 1'b0;
        tick(17);
        chk("rel_early", ss[0][0], 0);
        tick(1);
        chk("rel_state", ss[0][0], 1);
        chk("rel_count", ec[0], 1);
        chk("rel_count_rise", ec[1], 1);
        tick(5);
        chk("sb_drain", q0.size() + q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/switch_port.md
SWITCH_PORT -- requirements
Module: switch_port

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent switch inputs, 1..32.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16: number of consecutive stable synchronised samples required to accept a new level, 1..65535.
REQ-003 SHALL have parameter EDGE_MODE, default 2: edge type that sets a pending flag (0 rising, 1 falling, 2 both).
REQ-004 SHALL have port clock, input, 1 bit: single clock; all state SHALL be updated on its rising edge.
REQ-005 SHALL have port isReset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port switch, input, CHANNELS bits: raw, asynchronous switch levels.
REQ-007 SHALL have port clearPending, input, CHANNELS bits: write-one-to-clear mask for the pending flags, sampled each clock.
REQ-008 SHALL have port switchState, output, CHANNELS bits: debounced switch levels.
REQ-009 SHALL have port pending, output, CHANNELS bits: sticky edge-event flags.
REQ-010 SHALL have port eventCount, output, 8 bits: total accepted edge events, counting all channels and matching EDGE_MODE.
REQ-011 SHALL have port interrupt, output, 1 bit: high while any pending bit is set.

Function
REQ-012 SHALL pass each switch bit through a two-flop synchroniser before any other logic uses it.
REQ-013 SHALL give each channel a debounce counter of width clog2(DEBOUNCE_CYCLES+1).
- If the synchronised level equals switchState: counter SHALL be zero.
- If it differs: counter SHALL increment each cycle.
REQ-014 SHALL set switchState to the new level, and reset the counter to zero, on the cycle the counter reaches DEBOUNCE_CYCLES-1 with the level still differing.
- Accepted-change latency from the raw input changing SHALL be 2 + DEBOUNCE_CYCLES clocks.
REQ-015 SHALL reset the channel counter to zero if the synchronised level returns to switchState before acceptance (glitch rejected, no state change).
REQ-016 SHALL set pending[i] on the same clock edge that switchState[i] changes, when the change matches EDGE_MODE.
REQ-017 SHALL clear pending[i] on any clock where clearPending[i]=1 and no new qualifying edge occurs on that channel in that cycle.
REQ-018 SHALL give set priority when a qualifying edge and clearPending[i] occur in the same cycle: pending[i] stays 1.
REQ-019 SHALL increment eventCount by the number of channels with a qualifying edge in that cycle (0..CHANNELS).
- Arithmetic SHALL be modulo 256, wrapping from 255 to 0 without saturation.
REQ-020 SHALL drive interrupt as a registered OR of the pending bits, lagging pending by one clock.
REQ-021 SHALL make channels fully independent; activity on one channel SHALL NOT alter another channel's counter or state.

Reset
REQ-022 SHALL, while isReset=1, asynchronously force all of the following to 0, regardless of clock:
- synchroniser flops;
- debounce counters;
- switchState, pending and eventCount;
- interrupt.
REQ-023 SHALL treat reset asserted mid-debounce as follows: the partial count SHALL be discarded, and after release the debounce SHALL restart from zero.
REQ-024 SHALL produce no edge events from reset release itself. If a switch is high at release, its rising edge SHALL be accepted normally after 2 + DEBOUNCE_CYCLES clocks and SHALL then count as an event.

Verification
REQ-025 Bench SHALL cover a clean press: defaults, switch[0] 0->1 held 40 clocks -> switchState[0]=1 exactly 18 clocks after the change; pending[0]=1; eventCount=1; interrupt=1 one clock later.
REQ-026 Bench SHALL cover glitch rejection: switch[1] high for 10 clocks, then low -> switchState, pending and eventCount stay 0.
REQ-027 Bench SHALL cover simultaneous set/clear: clearPending[2]=1 on the cycle switchState[2] rises -> pending[2] remains 1; clearPending[2]=1 on the next cycle -> pending[2]=0; interrupt drops one clock after that.
REQ-028 Bench SHALL cover multi-channel counting and wrap: all 4 channels toggle together, EDGE_MODE=2, eventCount preloaded to 254 via prior events -> eventCount becomes 2 (wrap from 258).
REQ-029 Bench SHALL cover EDGE_MODE=0: switch[3] press then release -> pending set only on the rise; eventCount=1 after both edges.
REQ-030 Bench SHALL cover reset mid-debounce: isReset pulsed for 1 clock at count 10 with switch[0] held high -> all outputs 0 during reset; switchState[0]=1 exactly 18 clocks after release; eventCount=1.
